// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//   Produces an N-bit thermometer word with exactly min(count_in, N) ones,
//   LSB-aligned. One bit is shifted in per two-cycle CHECK/SHIFT iteration
//   behind a ready/start/done handshake.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     request, sampled only while rdy=1
//   count_in  requested number of ones (unsigned), sampled with start
//   rdy       high while idle and able to accept a request
//   done      one-cycle completion pulse
//   x_out     registered result word, held until the next completion
//   sat       count_in exceeded N on the last completed request
module ones_pattern_gen #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] count_in,
  output logic          rdy,
  output logic          done,
  output logic [N-1:0]  x_out,
  output logic          sat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] N_CW = CW'(N);

  state_t        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          satq_q, satq_d;
  logic [N-1:0]  x_q, x_d;
  logic          sat_q, sat_d;
  logic          ovf;

  // Both operands are CW bits wide, so N is compared zero-extended.
  assign ovf = (count_in > N_CW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      satq_q  <= 1'b0;
      x_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      satq_q  <= satq_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    satq_d  = satq_q;
    x_d     = x_q;
    sat_d   = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = ovf ? N_CW : count_in;
          satq_d  = ovf;
          work_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rem_q != '0) begin
          state_d = ST_SHIFT;
        end else begin
          // Result and saturation flag publish together on the edge into DONE.
          x_d     = work_q;
          sat_d   = satq_q;
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        // Entered only with rem_q != 0, so the decrement cannot wrap.
        work_d  = {work_q[N-2:0], 1'b1};
        rem_d   = rem_q - CW'(1);
        state_d = ST_CHECK;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rdy   = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign x_out = x_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen
//   Directed, table-driven bench for ones_pattern_gen with N=8, CW=4, plus
//   hand-written sequences for ignored start, held start and async reset.
module tb_ones_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] count_in;
  logic       rdy;
  logic       done;
  logic [7:0] x_out;
  logic       sat;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_x;

  ones_pattern_gen #(.N(8), .CW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .count_in (count_in),
    .rdy      (rdy),
    .done     (done),
    .x_out    (x_out),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] exp_x;
    logic       exp_sat;
    int         exp_lat;   // edges counted from the sampling edge (inclusive) to DONE entry
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge-aligned point and follow it to completion.
  task automatic run_req(input logic [3:0] c, input logic [7:0] ex, input logic es,
                         input int el, input string tag);
    int  n;
    int  rdy_hi;
    bit  seen;
    n = 0;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " rdy before start"}, 32'(rdy), 32'd1);
    start    = 1'b1;
    count_in = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    check({tag, " rdy after sample"}, 32'(rdy), 32'd0);
    check({tag, " x_out held"}, 32'(x_out), 32'(prev_x));
    seen   = 1'b0;
    rdy_hi = 0;
    while (!seen && n < 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (rdy !== 1'b0) rdy_hi++;
        @(posedge clk);
        #1;
        n++;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(el));
    check({tag, " rdy low in flight"}, 32'(rdy_hi), 32'd0);
    check({tag, " rdy low at done"}, 32'(rdy), 32'd0);
    check({tag, " x_out"}, 32'(x_out), 32'(ex));
    check({tag, " sat"}, 32'(sat), 32'(es));
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " rdy after done"}, 32'(rdy), 32'd1);
    check({tag, " x_out stable"}, 32'(x_out), 32'(ex));
    prev_x = ex;
    @(negedge clk);
  endtask

  initial begin
    int e;
    int last_done;
    int rdy_cnt;
    int ndone;

    vecs[0] = '{4'd3,  8'h07, 1'b0, 8};
    vecs[1] = '{4'd0,  8'h00, 1'b0, 2};
    vecs[2] = '{4'd8,  8'hFF, 1'b0, 18};
    vecs[3] = '{4'd12, 8'hFF, 1'b1, 18};
    vecs[4] = '{4'd1,  8'h01, 1'b0, 4};
    vecs[5] = '{4'd15, 8'hFF, 1'b1, 18};
    vecs[6] = '{4'd7,  8'h7F, 1'b0, 16};

    reset    = 1'b1;
    start    = 1'b0;
    count_in = '0;
    prev_x   = 8'h00;
    #1;
    check("reset rdy",   32'(rdy),   32'd1);
    check("reset done",  32'(done),  32'd0);
    check("reset x_out", 32'(x_out), 32'd0);
    check("reset sat",   32'(sat),   32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].cnt, vecs[i].exp_x, vecs[i].exp_sat, vecs[i].exp_lat,
              $sformatf("vec%0d", i));
    end

    // Second start during an in-flight request must be ignored.
    start    = 1'b1;
    count_in = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    e = 1;
    while (e < 4) begin
      @(posedge clk);
      #1;
      e++;
    end
    start    = 1'b1;
    count_in = 4'd2;
    @(posedge clk);
    #1;
    start    = 1'b0;
    count_in = 4'd0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    check("ignore done count", 32'(ndone), 32'd1);
    check("ignore x_out", 32'(x_out), 32'h1F);
    check("ignore sat", 32'(sat), 32'd0);
    prev_x = 8'h1F;
    @(negedge clk);

    // start held high: one request per completion, period 7 edges.
    start     = 1'b1;
    count_in  = 4'd2;
    last_done = -1;
    rdy_cnt   = 0;
    ndone     = 0;
    for (e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        check("held x_out", 32'(x_out), 32'h03);
        if (last_done >= 0) begin
          check("held period", 32'(e - last_done), 32'd7);
          check("held rdy cycles", 32'(rdy_cnt), 32'd1);
        end
        last_done = e;
        rdy_cnt   = 0;
      end else if (rdy === 1'b1) begin
        rdy_cnt++;
      end
    end
    check("held done count", 32'(ndone), 32'd3);
    start  = 1'b0;
    prev_x = 8'h03;
    @(negedge clk);

    // Async reset while a count=7 request sits in SHIFT.
    run_req(4'd5, 8'h1F, 1'b0, 12, "pre-reset");
    start    = 1'b1;
    count_in = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid reset rdy",   32'(rdy),   32'd1);
    check("mid reset x_out", 32'(x_out), 32'd0);
    check("mid reset done",  32'(done),  32'd0);
    check("mid reset sat",   32'(sat),   32'd0);
    @(negedge clk);
    reset  = 1'b0;
    prev_x = 8'h00;
    @(negedge clk);
    run_req(4'd2, 8'h03, 1'b0, 6, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
